// File: rtl/mips_bus_memory_pkg.sv
// Shared types and constants for the MIPS Avalon-MM bus memory.
package mips_bus_pkg;
   localparam int          WORD_W       = 32;
   localparam int          BE_W         = 4;
   localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

   typedef enum logic [1:0] {IDLE, WAIT, ACK} bus_state_t;

   // Request as captured on the accept cycle; wr is already cleared when rd wins.
   typedef struct packed {
      logic [WORD_W-1:0] addr;
      logic [WORD_W-1:0] wdata;
      logic [BE_W-1:0]   be;
      logic              rd;
      logic              wr;
   } bus_req_t;
endpackage

// File: rtl/mips_bus_memory_if.sv
// Avalon-MM bus between mips_cpu_bus (master) and the bus memory (slave).
interface mips_bus_memory_if;
   import mips_bus_pkg::*;
   logic [WORD_W-1:0] address;
   logic              read;
   logic              write;
   logic [WORD_W-1:0] writedata;
   logic [BE_W-1:0]   byteenable;
   logic              waitrequest;
   logic [WORD_W-1:0] readdata;
   logic              bus_error;

   modport master (output address, read, write, writedata, byteenable,
                   input  waitrequest, readdata, bus_error);
   modport slave  (input  address, read, write, writedata, byteenable,
                   output waitrequest, readdata, bus_error);
endinterface

// File: rtl/mips_bus_memory_byte_lane_ram.sv
// Word RAM with per-byte write enables, synchronous write and combinational read.
module byte_lane_ram
   import mips_bus_pkg::*;
#(
   parameter int    DEPTH_LOG2 = 12,
   parameter string INIT_FILE  = ""
) (
   input  logic                  clk,
   input  logic [DEPTH_LOG2-1:0] addr_i,
   input  logic [BE_W-1:0]       we_i,
   input  logic [WORD_W-1:0]     wdata_i,
   output logic [WORD_W-1:0]     rdata_o
);
   logic [BE_W-1:0][7:0] mem [2**DEPTH_LOG2];

   initial begin
      for (int i = 0; i < 2**DEPTH_LOG2; i++) mem[i] = '0;
   end

   always_ff @(posedge clk) begin
      for (int l = 0; l < BE_W; l++)
         if (we_i[l]) mem[addr_i][l] <= wdata_i[8*l +: 8];
   end

   assign rdata_o = mem[addr_i];
endmodule

// File: rtl/mips_bus_memory.sv
// Avalon-MM slave RAM at the MIPS reset vector with programmable wait states and a sticky error flag.
module mips_bus_memory
   import mips_bus_pkg::*;
#(
   parameter int          DEPTH_LOG2  = 12,
   parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
   parameter int          WAIT_CYCLES = 2,
   parameter string       INIT_FILE   = ""
) (
   input  logic               clk,
   input  logic               reset_n,
   mips_bus_memory_if.slave   bus
);
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   bus_state_t            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d, cnt_dec;
   bus_req_t              req_q, req_d;
   logic [WORD_W-1:0]     rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic                  req_vld, ack_entry, in_range;
   logic [DEPTH_LOG2-1:0] idx;
   logic [BE_W-1:0]       ram_we;
   logic [WORD_W-1:0]     ram_rdata;

   assign req_vld = bus.read | bus.write;
   assign cnt_dec = cnt_q - 4'd1;

   // Decode from req_d so a zero-wait access uses the address being accepted.
   assign in_range = ({1'b0, req_d.addr} >= {1'b0, BASE_ADDR}) &&
                     ({1'b0, req_d.addr} < ({1'b0, BASE_ADDR} + (33'd4 << DEPTH_LOG2)));
   assign idx      = DEPTH_LOG2'((req_d.addr - BASE_ADDR) >> 2);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      err_d   = err_q;
      case (state_q)
         IDLE: if (req_vld) begin
            req_d.addr  = bus.address;
            req_d.wdata = bus.writedata;
            req_d.be    = bus.byteenable;
            req_d.rd    = bus.read;
            req_d.wr    = bus.write & ~bus.read;
            cnt_d       = WAIT_INIT;
            state_d     = (WAIT_INIT == 4'd0) ? ACK : WAIT;
            if (bus.read & bus.write) err_d = 1'b1;
         end
         WAIT: begin
            if (!req_vld || bus.address != req_q.addr) begin
               state_d = IDLE;
               cnt_d   = '0;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_dec;
               if (cnt_dec == 4'd0) state_d = ACK;
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d == ACK && state_q != ACK && !in_range) err_d = 1'b1;
   end

   always_comb begin
      ack_entry = reset_n && (state_d == ACK) && (state_q != ACK);
      ram_we    = (ack_entry && req_d.wr && in_range) ? req_d.be : '0;
      rdata_d   = rdata_q;
      if (ack_entry && req_d.rd) rdata_d = in_range ? ram_rdata : '0;
   end

   assign bus.waitrequest = !reset_n | (req_vld & (state_q != ACK));
   assign bus.readdata    = rdata_q;
   assign bus.bus_error   = err_q;

   byte_lane_ram #(.DEPTH_LOG2(DEPTH_LOG2), .INIT_FILE(INIT_FILE)) u_ram (
      .clk     (clk),
      .addr_i  (idx),
      .we_i    (ram_we),
      .wdata_i (req_d.wdata),
      .rdata_o (ram_rdata)
   );
endmodule

// File: tb/tb_mips_bus_memory.sv
// Directed bench: one memory with 2 wait states, one with zero wait states.
module tb_mips_bus_memory;
   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mips_bus_memory_if bus2 ();
   mips_bus_memory_if bus0 ();

   mips_bus_memory #(.WAIT_CYCLES(2)) u_dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));
   mips_bus_memory #(.WAIT_CYCLES(0)) u_dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));

   // One transfer; lat = cycles from first request cycle to waitrequest low, -1 on timeout.
   task automatic xfer(input bit z, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       output logic [31:0] rdat, output int lat);
      @(posedge clk); #1;
      if (z) begin
         bus0.address = a; bus0.read = rd; bus0.write = wr; bus0.writedata = wd; bus0.byteenable = be;
      end else begin
         bus2.address = a; bus2.read = rd; bus2.write = wr; bus2.writedata = wd; bus2.byteenable = be;
      end
      lat  = -1;
      rdat = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!(z ? bus0.waitrequest : bus2.waitrequest)) begin
            lat  = i;
            rdat = z ? bus0.readdata : bus2.readdata;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      if (z) begin bus0.read = 0; bus0.write = 0; end
      else   begin bus2.read = 0; bus2.write = 0; end
   endtask

   task automatic test_reset();
      reset_n = 0;
      bus2.address = 32'hBFC0_0000; bus2.read = 1;
      bus0.address = 32'hBFC0_0000; bus0.read = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks += 4;
      if (bus2.waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wr2: got %b expected 1", bus2.waitrequest); end
      if (bus0.waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wr0: got %b expected 1", bus0.waitrequest); end
      if (bus2.readdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus2.readdata); end
      if (bus2.bus_error !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus2.bus_error); end
      reset_n = 1;
      @(negedge clk);
      checks += 2;
      if (bus0.waitrequest !== 1'b0) begin errors++; $display("FAIL release_ack0: got %b expected 0", bus0.waitrequest); end
      if (bus2.waitrequest !== 1'b1) begin errors++; $display("FAIL release_wait2: got %b expected 1", bus2.waitrequest); end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (bus2.waitrequest !== 1'b0) begin errors++; $display("FAIL release_ack2: got %b expected 0", bus2.waitrequest); end
      @(posedge clk); #1;
      bus2.read = 0; bus0.read = 0;
   endtask

   task automatic test_latency();
      logic [31:0] d; int lat;
      xfer(0, 0, 1, 32'hBFC0_0000, 32'h2402_0005, 4'hF, d, lat);
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL write_latency: got %0d expected 3", lat); end
      xfer(0, 1, 0, 32'hBFC0_0000, 32'h0, 4'h0, d, lat);
      checks += 2;
      if (lat !== 3) begin errors++; $display("FAIL read_latency: got %0d expected 3", lat); end
      if (d !== 32'h2402_0005) begin errors++; $display("FAIL read_data: got %h expected 24020005", d); end
   endtask

   task automatic test_byte_write();
      logic [31:0] d; int lat;
      xfer(0, 0, 1, 32'hBFC0_0004, 32'h1122_3344, 4'hF, d, lat);
      xfer(0, 0, 1, 32'hBFC0_0004, 32'h0000_AB00, 4'b0010, d, lat);
      xfer(0, 1, 0, 32'hBFC0_0004, 32'h0, 4'h0, d, lat);
      checks++;
      if (d !== 32'h1122_AB44) begin errors++; $display("FAIL byte_lane: got %h expected 1122ab44", d); end
      xfer(0, 0, 1, 32'hBFC0_0004, 32'hFFFF_FFFF, 4'b0000, d, lat);
      checks++;
      if (bus2.readdata !== 32'h1122_AB44) begin errors++; $display("FAIL rdata_hold: got %h expected 1122ab44", bus2.readdata); end
      xfer(0, 1, 0, 32'hBFC0_0004, 32'h0, 4'h0, d, lat);
      checks += 2;
      if (d !== 32'h1122_AB44) begin errors++; $display("FAIL be_zero: got %h expected 1122ab44", d); end
      if (bus2.bus_error !== 1'b0) begin errors++; $display("FAIL no_err: got %b expected 0", bus2.bus_error); end
   endtask

   task automatic test_out_of_range();
      logic [31:0] d; int lat;
      xfer(0, 1, 0, 32'h0000_0000, 32'h0, 4'h0, d, lat);
      checks += 3;
      if (lat !== 3) begin errors++; $display("FAIL oor_latency: got %0d expected 3", lat); end
      if (d !== 32'h0) begin errors++; $display("FAIL oor_rdata: got %h expected 0", d); end
      if (bus2.bus_error !== 1'b1) begin errors++; $display("FAIL oor_err: got %b expected 1", bus2.bus_error); end
      xfer(0, 0, 1, 32'hBFC0_4000, 32'hDEAD_BEEF, 4'hF, d, lat);
      xfer(0, 1, 0, 32'hBFC0_0000, 32'h0, 4'h0, d, lat);
      checks += 2;
      if (d !== 32'h2402_0005) begin errors++; $display("FAIL oor_write_dropped: got %h expected 24020005", d); end
      if (bus2.bus_error !== 1'b1) begin errors++; $display("FAIL oor_sticky: got %b expected 1", bus2.bus_error); end
   endtask

   task automatic test_abort();
      logic [31:0] d; int lat;
      @(posedge clk); #1 reset_n = 0;
      @(posedge clk); #1 reset_n = 1;
      @(negedge clk);
      checks++;
      if (bus2.bus_error !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b expected 0", bus2.bus_error); end
      xfer(0, 1, 0, 32'hBFC0_0000, 32'h0, 4'h0, d, lat);
      checks++;
      if (d !== 32'h2402_0005) begin errors++; $display("FAIL ram_retained: got %h expected 24020005", d); end
      // read dropped during WAIT
      @(posedge clk); #1 bus2.address = 32'hBFC0_0004; bus2.read = 1;
      @(posedge clk); #1 bus2.read = 0;
      @(posedge clk); @(negedge clk);
      checks += 2;
      if (bus2.bus_error !== 1'b1) begin errors++; $display("FAIL abort_err: got %b expected 1", bus2.bus_error); end
      if (bus2.readdata !== 32'h2402_0005) begin errors++; $display("FAIL abort_rdata: got %h expected 24020005", bus2.readdata); end
      // write whose address changes during WAIT
      @(posedge clk); #1 bus2.address = 32'hBFC0_0000; bus2.write = 1; bus2.writedata = 32'h0; bus2.byteenable = 4'hF;
      @(posedge clk); #1 bus2.address = 32'hBFC0_0008;
      @(posedge clk); #1 bus2.write = 0;
      xfer(0, 1, 0, 32'hBFC0_0000, 32'h0, 4'h0, d, lat);
      checks++;
      if (d !== 32'h2402_0005) begin errors++; $display("FAIL abort_no_write: got %h expected 24020005", d); end
      @(posedge clk); #1 reset_n = 0;
      @(negedge clk);
      checks++;
      if (bus2.bus_error !== 1'b0) begin errors++; $display("FAIL reset_clears_err: got %b expected 0", bus2.bus_error); end
      @(posedge clk); #1 reset_n = 1;
      // read and write together: read wins, write dropped, flag set
      xfer(0, 1, 1, 32'hBFC0_0004, 32'h0, 4'hF, d, lat);
      checks += 2;
      if (d !== 32'h1122_AB44) begin errors++; $display("FAIL rdwr_data: got %h expected 1122ab44", d); end
      if (bus2.bus_error !== 1'b1) begin errors++; $display("FAIL rdwr_err: got %b expected 1", bus2.bus_error); end
      xfer(0, 1, 0, 32'hBFC0_0004, 32'h0, 4'h0, d, lat);
      checks++;
      if (d !== 32'h1122_AB44) begin errors++; $display("FAIL rdwr_no_write: got %h expected 1122ab44", d); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d; int lat;
      @(posedge clk); #1 bus2.address = 32'hBFC0_0000; bus2.write = 1; bus2.writedata = 32'hCAFE_F00D; bus2.byteenable = 4'hF;
      @(posedge clk); #1 reset_n = 0;
      @(negedge clk);
      checks++;
      if (bus2.waitrequest !== 1'b1) begin errors++; $display("FAIL reset_mid_wr: got %b expected 1", bus2.waitrequest); end
      bus2.write = 0;
      @(posedge clk); #1 reset_n = 1;
      xfer(0, 1, 0, 32'hBFC0_0000, 32'h0, 4'h0, d, lat);
      checks += 2;
      if (d !== 32'h2402_0005) begin errors++; $display("FAIL reset_mid_ram: got %h expected 24020005", d); end
      if (bus2.bus_error !== 1'b0) begin errors++; $display("FAIL reset_mid_err: got %b expected 0", bus2.bus_error); end
   endtask

   task automatic test_zero_wait();
      logic [31:0] d; int lat;
      logic [31:0] exp_d [3];
      exp_d[0] = 32'hA0A0_0000; exp_d[1] = 32'hA1A1_1111; exp_d[2] = 32'hA2A2_2222;
      for (int k = 0; k < 3; k++) begin
         xfer(1, 0, 1, 32'hBFC0_0000 + 32'(4*k), exp_d[k], 4'hF, d, lat);
         checks++;
         if (lat !== 1) begin errors++; $display("FAIL zw_write_lat%0d: got %0d expected 1", k, lat); end
      end
      @(posedge clk); #1 bus0.address = 32'hBFC0_0000; bus0.read = 1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (bus0.waitrequest !== 1'b1) begin errors++; $display("FAIL zw_wait%0d: got %b expected 1", k, bus0.waitrequest); end
         @(negedge clk);
         checks += 2;
         if (bus0.waitrequest !== 1'b0) begin errors++; $display("FAIL zw_ack%0d: got %b expected 0", k, bus0.waitrequest); end
         if (bus0.readdata !== exp_d[k]) begin errors++; $display("FAIL zw_data%0d: got %h expected %h", k, bus0.readdata, exp_d[k]); end
         @(posedge clk); #1 bus0.address = 32'hBFC0_0000 + 32'(4*(k+1));
      end
      bus0.read = 0;
      @(negedge clk);
      checks++;
      if (bus0.bus_error !== 1'b0) begin errors++; $display("FAIL zw_err: got %b expected 0", bus0.bus_error); end
   endtask

   initial begin
      reset_n = 0;
      bus2.address = '0; bus2.read = 0; bus2.write = 0; bus2.writedata = '0; bus2.byteenable = '0;
      bus0.address = '0; bus0.read = 0; bus0.write = 0; bus0.writedata = '0; bus0.byteenable = '0;
      test_reset();
      test_latency();
      test_byte_write();
      test_out_of_range();
      test_abort();
      test_reset_mid();
      test_zero_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
